mt9p031_timing_gen: RTL and testbench
=====================================

Name: mt9p031_timing_gen

Overview:
- Sensor-model source stage for the MT9P031 testbench path: generates frame-valid / line-valid timing and test-pattern pixel data.
- Sits directly upstream of the noise-injection stage, which consumes its fval/lval/pixel stream unchanged in format.
- Geometry is programmable per frame so the frame-buffer benches can sweep resolutions and blanking without recompiling.

Parameters:
- DATA_WIDTH, 8, pixel width; legal range 8..16.

Ports:
- clk  input  1  pixel clock.
- reset  input  1  asynchronous, active-high reset.
- i_acquisition_start  input  1  1 = generate frames continuously; 0 = stop after the current frame.
- iv_line_active_pix_num  input  16  active pixels per line (A).
- iv_line_hide_pix_num  input  16  horizontal blanking clocks between lines (H).
- iv_frame_active_line_num  input  16  active lines per frame (L).
- iv_frame_hide_line_num  input  16  vertical blanking, in line periods (V).
- iv_fval_lval_gap  input  8  clocks between the fval edge and the nearest lval edge (G).
- iv_test_pattern_sel  input  2  0 = horizontal ramp, 1 = vertical ramp, 2 = diagonal moving, 3 = constant.
- o_fval  output  1  frame valid.
- o_lval  output  1  line valid.
- ov_pix_data  output  DATA_WIDTH  pixel data.
- ov_frame_cnt  output  16  completed-frame counter.

Behaviour:
- Reset, asynchronous: o_fval = 0, o_lval = 0, ov_pix_data = 0, ov_frame_cnt = 0, state = IDLE, all counters = 0.
- All outputs are registered.
- Geometry registers:
  - A, H, L, V and G are latched into shadow registers on each entry to VBLANK.
  - Input changes mid-frame have no effect until the next latch.
  - Every latched value of 0 is clamped to 1.
- States:
  - IDLE: all outputs 0. Sampling i_acquisition_start = 1 moves to VBLANK on the next edge.
  - VBLANK: fval = 0, lval = 0 for V×(A+H) clocks, then FRAME_LEAD.
  - FRAME_LEAD: fval = 1, lval = 0 for G clocks, then LINE_ACT.
  - LINE_ACT: fval = 1, lval = 1 for A clocks. Pixel counter px runs 0..A-1. Afterwards go to LINE_HIDE, or to FRAME_TRAIL if this was line L-1.
  - LINE_HIDE: fval = 1, lval = 0 for H clocks. Line counter ln increments, then LINE_ACT.
  - FRAME_TRAIL: fval = 1, lval = 0 for G clocks. Then fval falls, ov_frame_cnt increments (wraps at 0xFFFF→0), and the block goes to VBLANK if i_acquisition_start = 1, else IDLE.
- Frame timing: fval high time = 2G + L·A + (L-1)·H clocks. Frame period = fval high time + V·(A+H).
- Stop rule:
  - i_acquisition_start is sampled only at the end of FRAME_TRAIL.
  - Deassertion mid-frame never truncates a frame.
  - Deassertion in VBLANK does not abort VBLANK; one more full frame is produced.
- Pixel data, valid only while lval = 1; otherwise ov_pix_data = 0:
  - Pattern 0: px.
  - Pattern 1: ln.
  - Pattern 2: px + ln + frame_cnt, 16-bit modulo sum.
  - Pattern 3: constant 0x80 << (DATA_WIDTH-8).
  - Each pattern is truncated to the DATA_WIDTH LSBs.
  - iv_test_pattern_sel is latched with the geometry registers.
- Alignment: ov_pix_data changes on the same edge as o_lval, so the first active pixel coincides with lval rising.
- Counter widths: px, ln and the blanking counters are 16 bits; the VBLANK counter is 32 bits so V×(A+H) cannot overflow.
- Reset mid-frame: outputs drop to 0 immediately (asynchronous); restart is from IDLE.

Test Plan:
- Reset, then start = 1 with A=4, H=2, L=3, V=1, G=1, pattern 0 → 6 clocks of VBLANK, then fval high for exactly 18 clocks. Three lval pulses of 4 clocks each, separated by 2 clocks. Data per line is 0,1,2,3. Frame period is 24.
- Pattern 1 with A=4, L=3 → lines carry 0,0,0,0 / 1,1,1,1 / 2,2,2,2. Pattern 3 with DATA_WIDTH=12 → every active pixel = 0x800.
- Drop start during line 1 of frame 0 → that frame completes with 3 full lines, ov_frame_cnt goes to 1, the block returns to IDLE, and fval stays 0 thereafter.
- Change A from 4 to 6 mid-frame → the current frame keeps 4-clock lines; the next frame has 6-clock lines and 6×(6+2) = 48 clocks of VBLANK with V=6.
- All geometry inputs = 0 → clamped to 1: fval high for 3 clocks with a single 1-clock lval; VBLANK lasts 2 clocks.
- Assert reset during LINE_ACT → o_fval, o_lval and ov_pix_data read 0 before the next clk edge. After release with start = 1, the first frame is preceded by a full VBLANK and ov_frame_cnt = 0.

Source files
------------

// File: rtl/mt9p031_timing_gen_if.sv
// Control and video bus of the MT9P031 sensor-model timing generator.
// The slave modport is the generator; the master side drives geometry and start
// and consumes the fval/lval/pixel stream.
interface mt9p031_timing_gen_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  i_acquisition_start;
  logic [15:0]           iv_line_active_pix_num;
  logic [15:0]           iv_line_hide_pix_num;
  logic [15:0]           iv_frame_active_line_num;
  logic [15:0]           iv_frame_hide_line_num;
  logic [7:0]            iv_fval_lval_gap;
  logic [1:0]            iv_test_pattern_sel;
  logic                  o_fval;
  logic                  o_lval;
  logic [DATA_WIDTH-1:0] ov_pix_data;
  logic [15:0]           ov_frame_cnt;

  modport master (
    output i_acquisition_start, iv_line_active_pix_num, iv_line_hide_pix_num,
           iv_frame_active_line_num, iv_frame_hide_line_num, iv_fval_lval_gap,
           iv_test_pattern_sel,
    input  o_fval, o_lval, ov_pix_data, ov_frame_cnt
  );

  modport slave (
    input  i_acquisition_start, iv_line_active_pix_num, iv_line_hide_pix_num,
           iv_frame_active_line_num, iv_frame_hide_line_num, iv_fval_lval_gap,
           iv_test_pattern_sel,
    output o_fval, o_lval, ov_pix_data, ov_frame_cnt
  );
endinterface

// File: rtl/mt9p031_timing_gen.sv
// MT9P031 sensor-model source: frame/line valid timing with test-pattern pixels.
// Geometry and pattern select are latched on every entry to vertical blanking,
// so mid-frame input changes only take effect on the following frame.
module mt9p031_timing_gen #(
  parameter int DATA_WIDTH = 8
) (
  input logic                    clk,
  input logic                    reset,
  mt9p031_timing_gen_if.slave    bus
);

  typedef enum logic [2:0] {
    StIdle, StVblank, StFrameLead, StLineAct, StLineHide, StFrameTrail
  } state_e;

  localparam logic [15:0] PatConst = 16'h0080 << (DATA_WIDTH - 8);

  state_e state_q, state_d;

  // Shadow geometry (A, H, L, V, G) and pattern select.
  logic [15:0] a_q, a_d, h_q, h_d, l_q, l_d, v_q, v_d;
  logic [7:0]  g_q, g_d;
  logic [1:0]  sel_q, sel_d;

  logic [31:0] vb_cnt_q, vb_cnt_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] px_q, px_d;
  logic [15:0] ln_q, ln_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  logic                  fval_q, fval_d;
  logic                  lval_q, lval_d;
  logic [DATA_WIDTH-1:0] pix_q, pix_d;

  logic        latch;
  logic [31:0] vb_total;
  logic [15:0] gap_m1;
  logic [15:0] pat;

  function automatic logic [15:0] clamp16(input logic [15:0] x);
    return (x == 16'd0) ? 16'd1 : x;
  endfunction

  // Shadow values are never 0 after latching, so the minus-one compares cannot underflow.
  assign vb_total = 32'(v_q) * (32'(a_q) + 32'(h_q));
  assign gap_m1   = {8'd0, g_q} - 16'd1;

  // Next-state, counters and registered-output next values.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    h_d         = h_q;
    l_d         = l_q;
    v_d         = v_q;
    g_d         = g_q;
    sel_d       = sel_q;
    vb_cnt_d    = vb_cnt_q;
    cnt_d       = cnt_q;
    px_d        = px_q;
    ln_d        = ln_q;
    frame_cnt_d = frame_cnt_q;
    latch       = 1'b0;
    pat         = 16'd0;

    case (state_q)
      StIdle: begin
        if (bus.i_acquisition_start) begin
          state_d = StVblank;
          latch   = 1'b1;
        end
      end
      StVblank: begin
        if (vb_cnt_q == vb_total - 32'd1) begin
          state_d = StFrameLead;
          cnt_d   = 16'd0;
        end else begin
          vb_cnt_d = vb_cnt_q + 32'd1;
        end
      end
      StFrameLead: begin
        if (cnt_q == gap_m1) begin
          state_d = StLineAct;
          px_d    = 16'd0;
          ln_d    = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StLineAct: begin
        if (px_q == a_q - 16'd1) begin
          cnt_d   = 16'd0;
          state_d = (ln_q == l_q - 16'd1) ? StFrameTrail : StLineHide;
        end else begin
          px_d = px_q + 16'd1;
        end
      end
      StLineHide: begin
        if (cnt_q == h_q - 16'd1) begin
          state_d = StLineAct;
          px_d    = 16'd0;
          ln_d    = ln_q + 16'd1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StFrameTrail: begin
        if (cnt_q == gap_m1) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          if (bus.i_acquisition_start) begin
            state_d = StVblank;
            latch   = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (latch) begin
      a_d      = clamp16(bus.iv_line_active_pix_num);
      h_d      = clamp16(bus.iv_line_hide_pix_num);
      l_d      = clamp16(bus.iv_frame_active_line_num);
      v_d      = clamp16(bus.iv_frame_hide_line_num);
      g_d      = (bus.iv_fval_lval_gap == 8'd0) ? 8'd1 : bus.iv_fval_lval_gap;
      sel_d    = bus.iv_test_pattern_sel;
      vb_cnt_d = 32'd0;
    end

    // Outputs follow the next state so data and lval change on the same edge.
    fval_d = (state_d == StFrameLead) || (state_d == StLineAct) ||
             (state_d == StLineHide) || (state_d == StFrameTrail);
    lval_d = (state_d == StLineAct);

    case (sel_q)
      2'd0:    pat = px_d;
      2'd1:    pat = ln_d;
      2'd2:    pat = px_d + ln_d + frame_cnt_q;
      default: pat = PatConst;
    endcase
    pix_d = lval_d ? pat[DATA_WIDTH-1:0] : '0;
  end

  // State, shadow and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      a_q         <= 16'd0;
      h_q         <= 16'd0;
      l_q         <= 16'd0;
      v_q         <= 16'd0;
      g_q         <= 8'd0;
      sel_q       <= 2'd0;
      vb_cnt_q    <= 32'd0;
      cnt_q       <= 16'd0;
      px_q        <= 16'd0;
      ln_q        <= 16'd0;
      frame_cnt_q <= 16'd0;
      fval_q      <= 1'b0;
      lval_q      <= 1'b0;
      pix_q       <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      h_q         <= h_d;
      l_q         <= l_d;
      v_q         <= v_d;
      g_q         <= g_d;
      sel_q       <= sel_d;
      vb_cnt_q    <= vb_cnt_d;
      cnt_q       <= cnt_d;
      px_q        <= px_d;
      ln_q        <= ln_d;
      frame_cnt_q <= frame_cnt_d;
      fval_q      <= fval_d;
      lval_q      <= lval_d;
      pix_q       <= pix_d;
    end
  end

  assign bus.o_fval       = fval_q;
  assign bus.o_lval       = lval_q;
  assign bus.ov_pix_data  = pix_q;
  assign bus.ov_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_mt9p031_timing_gen.sv
// Self-checking bench for mt9p031_timing_gen: a frame-level reference model expands
// each latched geometry into the expected per-clock {fval, lval, pixel, frame_cnt} stream.
module tb_mt9p031_timing_gen;

  localparam int DW = 12;
  localparam int TW = DW + 18;

  typedef struct {
    int a;
    int h;
    int l;
    int v;
    int g;
    int sel;
  } cfg_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  int   fc_model = 0;
  cfg_t cur;

  mt9p031_timing_gen_if #(.DATA_WIDTH(DW)) bus ();

  mt9p031_timing_gen #(.DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout, required completion");
    $fatal(1, "watchdog");
  end

  function automatic int clampv(input int x);
    return (x == 0) ? 1 : x;
  endfunction

  function automatic logic [DW-1:0] pix_ref(input int px, input int ln, input int fc,
                                            input int sel);
    logic [31:0] t;
    case (sel)
      0:       t = px;
      1:       t = ln;
      2:       t = (px + ln + fc) % 65536;
      default: t = 128 * (1 << (DW - 8));
    endcase
    return t[DW-1:0];
  endfunction

  function automatic logic [TW-1:0] obs();
    return {bus.o_fval, bus.o_lval, bus.ov_pix_data, bus.ov_frame_cnt};
  endfunction

  function automatic cfg_t rand_cfg();
    cfg_t c;
    c.a   = $urandom_range(0, 8);
    c.h   = $urandom_range(0, 4);
    c.l   = $urandom_range(0, 4);
    c.v   = $urandom_range(0, 3);
    c.g   = $urandom_range(0, 3);
    c.sel = $urandom_range(0, 3);
    return c;
  endfunction

  task automatic drive(input cfg_t c);
    bus.iv_line_active_pix_num   = 16'(c.a);
    bus.iv_line_hide_pix_num     = 16'(c.h);
    bus.iv_frame_active_line_num = 16'(c.l);
    bus.iv_frame_hide_line_num   = 16'(c.v);
    bus.iv_fval_lval_gap         = 8'(c.g);
    bus.iv_test_pattern_sel      = 2'(c.sel);
  endtask

  task automatic check(input string tag, input logic [TW-1:0] o, input logic [TW-1:0] e);
    n_checks++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic check_int(input string tag, input int o, input int e);
    n_checks++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, o, e);
    end
  endtask

  // Runs one frame from its first VBLANK clock; optionally changes inputs at clock chg_idx.
  task automatic run_frame(input string name, input int chg_idx, input cfg_t nc,
                           input bit nstart, output int vb_seen, output int fv_seen);
    logic [TW-1:0] q[$];
    logic [15:0]   fc;
    int a, h, l, v, g, sel;
    a   = clampv(cur.a);
    h   = clampv(cur.h);
    l   = clampv(cur.l);
    v   = clampv(cur.v);
    g   = clampv(cur.g);
    sel = cur.sel;
    fc  = 16'(fc_model);
    for (int i = 0; i < v * (a + h); i++) q.push_back({2'b00, {DW{1'b0}}, fc});
    for (int i = 0; i < g; i++) q.push_back({2'b10, {DW{1'b0}}, fc});
    for (int ln = 0; ln < l; ln++) begin
      for (int px = 0; px < a; px++) q.push_back({2'b11, pix_ref(px, ln, fc_model, sel), fc});
      if (ln < l - 1) for (int i = 0; i < h; i++) q.push_back({2'b10, {DW{1'b0}}, fc});
    end
    for (int i = 0; i < g; i++) q.push_back({2'b10, {DW{1'b0}}, fc});
    vb_seen = 0;
    fv_seen = 0;
    for (int i = 0; i < q.size(); i++) begin
      @(posedge clk);
      #1;
      check($sformatf("%s cyc %0d", name, i), obs(), q[i]);
      if (bus.o_fval) fv_seen++;
      else if (fv_seen == 0) vb_seen++;
      if (i == chg_idx) begin
        cur = nc;
        drive(nc);
        bus.i_acquisition_start = nstart;
      end
    end
    fc_model = (fc_model + 1) % 65536;
  endtask

  task automatic check_idle(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("%s idle %0d", name, i), obs(), {2'b00, {DW{1'b0}}, 16'(fc_model)});
    end
  endtask

  initial begin
    cfg_t z;
    cfg_t c;
    int   vb;
    int   fv;
    int   found;
    z = '{0, 0, 0, 0, 0, 0};
    cur = z;
    drive(z);
    bus.i_acquisition_start = 1'b0;

    // Reset state and idle with start low.
    #12;
    check("reset", obs(), '0);
    #11 reset = 1'b0;
    check_idle("post-reset", 3);

    // Basic frame: A=4 H=2 L=3 V=1 G=1, horizontal ramp.
    cur = '{4, 2, 3, 1, 1, 0};
    drive(cur);
    bus.i_acquisition_start = 1'b1;
    run_frame("f0", -1, cur, 1'b1, vb, fv);
    check_int("f0 vblank", vb, 6);
    check_int("f0 fval high", fv, 18);
    check_int("f0 period", vb + fv, 24);

    // A changes 4->6 (with V=6, vertical ramp) mid-frame; current frame unaffected.
    c = '{6, 2, 3, 6, 1, 1};
    run_frame("f1", 12, c, 1'b1, vb, fv);
    check_int("f1 fval high", fv, 18);

    // Next frame uses the new geometry.
    c = '{4, 2, 3, 1, 1, 3};
    run_frame("f2", 5, c, 1'b1, vb, fv);
    check_int("f2 vblank", vb, 48);
    check_int("f2 fval high", fv, 24);

    // Constant pattern; start dropped during line 1 -> frame completes, then idle.
    run_frame("f3", 14, cur, 1'b0, vb, fv);
    check_int("f3 fval high", fv, 18);
    check_idle("f3 stop", 8);

    // All-zero geometry clamps to 1.
    cur = z;
    drive(z);
    bus.i_acquisition_start = 1'b1;
    run_frame("clamp", 0, z, 1'b0, vb, fv);
    check_int("clamp vblank", vb, 2);
    check_int("clamp fval high", fv, 3);
    check_idle("clamp stop", 3);

    // Random geometries, changed at random points, continuous acquisition.
    cur = rand_cfg();
    drive(cur);
    bus.i_acquisition_start = 1'b1;
    for (int k = 0; k < 8; k++) begin
      c = rand_cfg();
      run_frame($sformatf("rnd%0d", k), $urandom_range(0, 20), c, 1'b1, vb, fv);
    end

    // Asynchronous reset during LINE_ACT.
    found = 0;
    for (int i = 0; i < 2000 && found == 0; i++) begin
      @(posedge clk);
      #1;
      if (bus.o_lval) found = 1;
    end
    check_int("lval seen before reset", found, 1);
    #2 reset = 1'b1;
    #1;
    check("async reset", obs(), '0);
    @(posedge clk);
    cur = '{4, 2, 3, 2, 1, 2};
    drive(cur);
    #3 reset = 1'b0;
    fc_model = 0;
    run_frame("after reset", 20, cur, 1'b0, vb, fv);
    check_int("after reset vblank", vb, 12);
    check_int("after reset fval high", fv, 18);
    check_idle("after reset stop", 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
